// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: serialises cache word writes and 64-bit line reads onto a 16-bit async SRAM
//   clk, rst          clock, asynchronous active-high reset
//   rdEn, wrEn        line-read / word-write requests, held until ready
//   address           byte address (BASE_ADDR maps to halfword 0)
//   writeData         32-bit write word
//   readData          assembled line {hw3,hw2,hw1,hw0}
//   ready             transaction complete, or idle with nothing requested
//   SRAM_*            async SRAM pins (CE/UB/LB tied active)
module sram_burst_ctrl #(
    parameter int BASE_ADDR  = 1024,
    parameter int ACCESS_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdEn,
    input  logic        wrEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [63:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    localparam int CW = $clog2(ACCESS_CYC);
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYC - 1);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state;
    logic [1:0] idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [15:0] dq_out;
    logic [15:0] wr_hi;
    logic dq_oe;
    logic [31:0] off;
    assign off = address - 32'(BASE_ADDR);
    assign cnt_nx = (cnt == LAST) ? '0 : cnt + CW'(1);
    assign ready = (state == DONE) | (state == IDLE & ~rdEn & ~wrEn);
    assign SRAM_DQ = dq_oe ? dq_out : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            readData  <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            wr_hi     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (wrEn) begin
                        // high half is latched so a late change of writeData cannot corrupt it
                        state     <= WRITE;
                        SRAM_ADDR <= {off[18:2], 1'b0};
                        dq_out    <= writeData[15:0];
                        wr_hi     <= writeData[31:16];
                        dq_oe     <= 1'b1;
                        SRAM_WE_N <= 1'b0;
                    end else if (rdEn) begin
                        state     <= READ;
                        SRAM_ADDR <= {off[18:3], 2'b00};
                        SRAM_OE_N <= 1'b0;
                    end
                end
                READ: begin
                    cnt <= cnt_nx;
                    if (cnt == LAST) begin
                        readData[{idx, 4'b0000} +: 16] <= SRAM_DQ;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state     <= DONE;
                            SRAM_OE_N <= 1'b1;
                        end else
                            SRAM_ADDR <= SRAM_ADDR + 18'd1;
                    end
                end
                WRITE: begin
                    cnt <= cnt_nx;
                    // WE_N rises for the last cycle of each access so the write lands before the address moves
                    SRAM_WE_N <= (cnt_nx == LAST);
                    if (cnt == LAST) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd1) begin
                            state     <= DONE;
                            SRAM_WE_N <= 1'b1;
                            dq_oe     <= 1'b0;
                        end else begin
                            SRAM_ADDR <= SRAM_ADDR + 18'd1;
                            dq_out    <= wr_hi;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
